mario_anim: RTL and testbench
=============================

# mario_anim

Sprite-frame sequencer between the Mario sprite ROMs and `color_mapper`. It tracks Mario's animation state, facing direction and walk-cycle phase once per video frame. Per pixel, it selects one of the eleven ROM outputs and pipelines it together with the in-sprite flag so colour and flag reach `color_mapper` aligned. It also suppresses the transparent key colour so the background shows through.

## Interface
Parameters:
- `FRAMES_PER_STEP`, default 6: number of frame ticks per walk-cycle phase advance; legal range 1..63.
- `TRANSPARENT`, default 24'hFF00FF: ROM key colour treated as "not Mario".
- `KEY_LEFT`, default 8'h04: HID usage code for "move left" (A).
- `KEY_RIGHT`, default 8'h07: HID usage code for "move right" (D).

Ports (clock and reset first):
- `Clk`  in  1  system clock; single clock domain.
- `Reset`  in  1  asynchronous, active-high reset.
- `frame_clk`  in  1  VGA_VS; synchronous to `Clk`.
- `keycode`  in  16  two HID keycodes: [7:0] and [15:8].
- `mario_alive`  in  1  0 = dead.
- `mario_in_air`  in  1  from `mario_s`.
- `mario`  in  1  combinational in-sprite flag for the current DrawX/DrawY.
- `mario_sr`, `mario_sl`, `mario_rr1`, `mario_rr2`, `mario_rr3`, `mario_rl1`, `mario_rl2`, `mario_rl3`, `mario_jr`, `mario_jl`, `mario_die`  in  24 each  ROM data; each ROM has 1-cycle read latency.
- `mario_pic_out`  out  24  selected pixel colour, registered.
- `mario_vis`  out  1  registered "draw Mario here" flag.
- `facing_left`  out  1  current facing direction.
- `anim_state`  out  2  current state, encoded as `anim_state_t`.

## Operation
- `frame_tick` is a one-`Clk` pulse on each rising edge of `frame_clk` (end of vsync). The previous-value register resets to 1, so reset produces no tick.
- Key decode, evaluated each cycle:
  - `l` = either keycode byte equals `KEY_LEFT`.
  - `r` = either keycode byte equals `KEY_RIGHT`.
- State machine; it updates only on `frame_tick`. Priority is evaluated top-down:
  - `!mario_alive` → S_DEAD. S_DEAD is sticky until `Reset`.
  - `mario_in_air` → S_JUMP.
  - `l ^ r` → S_WALK.
  - Otherwise → S_STAND. Pressing both keys counts as no key.
- Facing: on `frame_tick` outside S_DEAD, `l & !r` sets `facing_left = 1` and `r & !l` clears it. Otherwise facing holds. Facing updates in S_JUMP as well.
- Walk cycle: a 6-bit frame counter `fcnt` and a 2-bit `phase`.
  - Entering S_WALK from any other state clears both.
  - While in S_WALK, each `frame_tick` increments `fcnt`. At `FRAMES_PER_STEP-1`, `fcnt` wraps to 0 and `phase` advances 0→1→2→0; phase value 3 is never reached.
  - Outside S_WALK, both hold.
- Frame selection, combinational from the registered state:
  - S_STAND: `sr` / `sl`.
  - S_WALK: `rr{phase+1}` / `rl{phase+1}`.
  - S_JUMP: `jr` / `jl`.
  - S_DEAD: `die`, regardless of facing.

## Timing
- Reset values: state S_STAND, `facing_left` 0, `fcnt` 0, `phase` 0, `mario_pic_out` 24'h0, `mario_vis` 0, flag delay register 0.
- Pixel pipeline:
  - Stage 1: register `mario` into `mario_d1`, which aligns it with ROM data.
  - Stage 2: register the mux output into `mario_pic_out`, and `mario_d1 & (mux != TRANSPARENT)` into `mario_vis`.
  - Total latency from `mario` to the outputs is 2 `Clk`. Throughput is one pixel per clock.
- State, facing and phase change only in the cycle after `frame_tick`, i.e. during vertical blanking, so no mid-frame tearing occurs.
- Reset asserted mid-frame clears all registers immediately. `mario_vis` is 0 until the first valid pixel has propagated 2 cycles after release.

## Structure
- Package `mario_pkg` holds:
  - `typedef enum logic [1:0] {S_STAND, S_WALK, S_JUMP, S_DEAD} anim_state_t`.
  - Constants `KEY_LEFT_C = 8'h04`, `KEY_RIGHT_C = 8'h07`, `TRANSPARENT_C = 24'hFF00FF`.
- One sub-module: `frame_tick_gen` (rising-edge pulse generator, reset to 1). Everything else lives in `mario_anim`.

## Test plan
- Reset, then 3 frames with `keycode` = 0 and alive → `anim_state` = S_STAND, `facing_left` = 0, and a pixel equal to `mario_sr` = 24'h123456 with `mario` = 1 appears as `mario_pic_out` = 24'h123456 and `mario_vis` = 1 exactly 2 cycles later.
- `keycode` = 16'h0007 for 19 frames with `FRAMES_PER_STEP` = 6 → S_WALK with selected ROM rr1 for 6 frames, rr2 for 6 frames, rr3 for 6 frames, then rr1 again.
- `keycode` = 16'h0400 (high byte) → `facing_left` = 1 after the next tick and rl1 is selected. Then `keycode` = 16'h0407 → S_STAND, `facing_left` stays 1, and `sl` is selected.
- `mario_in_air` = 1 while left is held → `jl` selected. Then `mario_alive` = 0 with `mario_in_air` still 1 → S_DEAD and `die` selected. Releasing everything leaves it in S_DEAD until `Reset`.
- ROM pixel = 24'hFF00FF with `mario` = 1 → `mario_vis` = 0 two cycles later. ROM pixel = 24'hFF00FE → `mario_vis` = 1.
- `Reset` pulse mid-walk (phase 2) → all outputs 0 and state S_STAND immediately, with no `frame_tick` on release even while `frame_clk` = 1.

Source files
------------

// File: rtl/mario_pkg.sv
// Shared types and constants for the Mario sprite-frame sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mario_pkg;

    // Animation state, also exported on the anim_state port.
    typedef enum logic [1:0] {
        S_STAND = 2'd0,
        S_WALK  = 2'd1,
        S_JUMP  = 2'd2,
        S_DEAD  = 2'd3
    } anim_state_t;

    // HID usage codes for the A / D keys and the sprite ROM key colour.
    localparam logic [7:0]  KEY_LEFT_C    = 8'h04;
    localparam logic [7:0]  KEY_RIGHT_C   = 8'h07;
    localparam logic [23:0] TRANSPARENT_C = 24'hFF00FF;

    // True when either byte of the two-key HID report matches the code.
    function automatic logic key_hit(input logic [15:0] keycode, input logic [7:0] code);
        return (keycode[7:0] == code) || (keycode[15:8] == code);
    endfunction

endpackage

// File: rtl/mario_anim_frame_tick_gen.sv
// Rising-edge detector on the vertical-sync strobe: one Clk pulse per frame.
// Latency: combinational pulse in the first Clk cycle frame_clk is seen high.
// Backpressure: none; free-running.
//
// Ports: Clk/Reset (async active-high), frame_clk (VGA_VS, synchronous to Clk),
//        frame_tick (one-cycle pulse).
module frame_tick_gen (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic frame_tick
);

    // Previous-value register resets to 1 so that releasing reset while
    // frame_clk is already high does not fabricate a tick.
    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = frame_clk;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign frame_tick = frame_clk & ~prev_q;

endmodule

// File: rtl/mario_anim.sv
// Mario sprite-frame sequencer: per-frame animation FSM plus per-pixel ROM select.
// Latency: 2 Clk from mario flag to mario_pic_out/mario_vis; state changes 1 Clk after frame_tick.
// Backpressure: none; accepts one pixel per Clk.
//
// Ports: Clk/Reset (async active-high); frame_clk (VGA_VS); keycode (two HID bytes);
//        mario_alive, mario_in_air (game state); mario (in-sprite flag);
//        eleven 24-bit ROM outputs (1-cycle read latency);
//        mario_pic_out, mario_vis (registered pixel out); facing_left, anim_state.
module mario_anim
    import mario_pkg::*;
#(
    parameter int          FRAMES_PER_STEP = 6,
    parameter logic [23:0] TRANSPARENT     = TRANSPARENT_C,
    parameter logic [7:0]  KEY_LEFT        = KEY_LEFT_C,
    parameter logic [7:0]  KEY_RIGHT       = KEY_RIGHT_C
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [15:0] keycode,
    input  logic        mario_alive,
    input  logic        mario_in_air,
    input  logic        mario,
    input  logic [23:0] mario_sr,
    input  logic [23:0] mario_sl,
    input  logic [23:0] mario_rr1,
    input  logic [23:0] mario_rr2,
    input  logic [23:0] mario_rr3,
    input  logic [23:0] mario_rl1,
    input  logic [23:0] mario_rl2,
    input  logic [23:0] mario_rl3,
    input  logic [23:0] mario_jr,
    input  logic [23:0] mario_jl,
    input  logic [23:0] mario_die,
    output logic [23:0] mario_pic_out,
    output logic        mario_vis,
    output logic        facing_left,
    output logic [1:0]  anim_state
);

    localparam logic [5:0] FCNT_LAST = 6'(FRAMES_PER_STEP - 1);

    // ------------------------------------------------------------------
    // Frame tick
    // ------------------------------------------------------------------
    logic frame_tick;

    frame_tick_gen u_frame_tick_gen (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .frame_tick (frame_tick)
    );

    // ------------------------------------------------------------------
    // Key decode
    // ------------------------------------------------------------------
    logic key_l;
    logic key_r;

    assign key_l = key_hit(keycode, KEY_LEFT);
    assign key_r = key_hit(keycode, KEY_RIGHT);

    // ------------------------------------------------------------------
    // Animation state, facing and walk cycle (update only on frame_tick)
    // ------------------------------------------------------------------
    anim_state_t state_q,  state_d;
    logic        facing_q, facing_d;
    logic [5:0]  fcnt_q,   fcnt_d;
    logic [1:0]  phase_q,  phase_d;

    always_comb begin
        state_d  = state_q;
        facing_d = facing_q;
        fcnt_d   = fcnt_q;
        phase_d  = phase_q;

        if (frame_tick && state_q != S_DEAD) begin
            // Priority: death, airborne, exactly one direction key, idle.
            // Both keys held cancel each other and read as idle.
            if (!mario_alive) begin
                state_d = S_DEAD;
            end else if (mario_in_air) begin
                state_d = S_JUMP;
            end else if (key_l ^ key_r) begin
                state_d = S_WALK;
            end else begin
                state_d = S_STAND;
            end

            // Facing follows a lone direction key, including mid-jump.
            if (key_l && !key_r) begin
                facing_d = 1'b1;
            end else if (key_r && !key_l) begin
                facing_d = 1'b0;
            end

            if (state_d == S_WALK) begin
                if (state_q != S_WALK) begin
                    // Fresh walk always starts on the first stride frame.
                    fcnt_d  = 6'd0;
                    phase_d = 2'd0;
                end else if (fcnt_q == FCNT_LAST) begin
                    fcnt_d  = 6'd0;
                    phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
                end else begin
                    fcnt_d  = fcnt_q + 6'd1;
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_STAND;
            facing_q <= 1'b0;
            fcnt_q   <= 6'd0;
            phase_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            facing_q <= facing_d;
            fcnt_q   <= fcnt_d;
            phase_q  <= phase_d;
        end
    end

    assign facing_left = facing_q;
    assign anim_state  = state_q;

    // ------------------------------------------------------------------
    // ROM frame select (combinational from registered state)
    // ------------------------------------------------------------------
    logic [23:0] pix_mux;
    logic [23:0] walk_r;
    logic [23:0] walk_l;

    always_comb begin
        // Phase 3 never occurs; fall back to the first stride frame.
        case (phase_q)
            2'd1:    begin walk_r = mario_rr2; walk_l = mario_rl2; end
            2'd2:    begin walk_r = mario_rr3; walk_l = mario_rl3; end
            default: begin walk_r = mario_rr1; walk_l = mario_rl1; end
        endcase
    end

    always_comb begin
        case (state_q)
            S_WALK:  pix_mux = facing_q ? walk_l   : walk_r;
            S_JUMP:  pix_mux = facing_q ? mario_jl : mario_jr;
            S_DEAD:  pix_mux = mario_die;
            default: pix_mux = facing_q ? mario_sl : mario_sr;
        endcase
    end

    // ------------------------------------------------------------------
    // Pixel pipeline
    // ------------------------------------------------------------------
    // Stage 1 delays the in-sprite flag to line up with the ROM data, which
    // arrives one cycle after its address. Stage 2 registers colour and the
    // visibility flag together, masking out the ROM key colour.
    logic        mario_d1_q, mario_d1_d;
    logic [23:0] pic_q,      pic_d;
    logic        vis_q,      vis_d;

    always_comb begin
        mario_d1_d = mario;
        pic_d      = pix_mux;
        vis_d      = mario_d1_q & (pix_mux != TRANSPARENT);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mario_d1_q <= 1'b0;
            pic_q      <= 24'h0;
            vis_q      <= 1'b0;
        end else begin
            mario_d1_q <= mario_d1_d;
            pic_q      <= pic_d;
            vis_q      <= vis_d;
        end
    end

    assign mario_pic_out = pic_q;
    assign mario_vis     = vis_q;

endmodule

// File: tb/tb_mario_anim.sv
// Directed bench for mario_anim: reset state, pixel latency, walk cycle,
// facing, jump/death priority, transparency and mid-walk reset.
// Inputs are driven and outputs sampled on the falling edge of Clk.
module tb_mario_anim;

    localparam logic [23:0] C_SR  = 24'h123456;
    localparam logic [23:0] C_SL  = 24'h222222;
    localparam logic [23:0] C_RR1 = 24'h331111;
    localparam logic [23:0] C_RR2 = 24'h332222;
    localparam logic [23:0] C_RR3 = 24'h333333;
    localparam logic [23:0] C_RL1 = 24'h441111;
    localparam logic [23:0] C_RL2 = 24'h442222;
    localparam logic [23:0] C_RL3 = 24'h443333;
    localparam logic [23:0] C_JR  = 24'h550000;
    localparam logic [23:0] C_JL  = 24'h560000;
    localparam logic [23:0] C_DIE = 24'h660000;

    localparam logic [1:0] ST_STAND = 2'd0;
    localparam logic [1:0] ST_WALK  = 2'd1;
    localparam logic [1:0] ST_JUMP  = 2'd2;
    localparam logic [1:0] ST_DEAD  = 2'd3;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic [15:0] keycode;
    logic        mario_alive;
    logic        mario_in_air;
    logic        mario;
    logic [23:0] mario_sr;
    logic [23:0] mario_pic_out;
    logic        mario_vis;
    logic        facing_left;
    logic [1:0]  anim_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    mario_anim dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_clk     (frame_clk),
        .keycode       (keycode),
        .mario_alive   (mario_alive),
        .mario_in_air  (mario_in_air),
        .mario         (mario),
        .mario_sr      (mario_sr),
        .mario_sl      (C_SL),
        .mario_rr1     (C_RR1),
        .mario_rr2     (C_RR2),
        .mario_rr3     (C_RR3),
        .mario_rl1     (C_RL1),
        .mario_rl2     (C_RL2),
        .mario_rl3     (C_RL3),
        .mario_jr      (C_JR),
        .mario_jl      (C_JL),
        .mario_die     (C_DIE),
        .mario_pic_out (mario_pic_out),
        .mario_vis     (mario_vis),
        .facing_left   (facing_left),
        .anim_state    (anim_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One video frame: frame_clk high for two cycles, low for two.
    // The tick lands on the first edge; the pixel output catches up one edge later.
    task automatic frame();
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk);
        @(negedge Clk) frame_clk = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [23:0] exp_walk;

        Reset        = 1'b1;
        frame_clk    = 1'b0;
        keycode      = 16'h0;
        mario_alive  = 1'b1;
        mario_in_air = 1'b0;
        mario        = 1'b0;
        mario_sr     = C_SR;

        repeat (3) @(negedge Clk);
        check("rst_pic",    mario_pic_out, 24'h0);
        check("rst_vis",    mario_vis,     1'b0);
        check("rst_state",  anim_state,    ST_STAND);
        check("rst_facing", facing_left,   1'b0);
        Reset = 1'b0;

        // Idle for three frames.
        repeat (3) frame();
        check("idle_state",  anim_state,  ST_STAND);
        check("idle_facing", facing_left, 1'b0);

        // Single-cycle mario flag appears on mario_vis exactly two edges later.
        @(negedge Clk) mario = 1'b1;
        @(negedge Clk) mario = 1'b0;
        check("lat_vis_1", mario_vis, 1'b0);
        @(negedge Clk);
        check("lat_vis_2", mario_vis,     1'b1);
        check("lat_pic_2", mario_pic_out, C_SR);
        @(negedge Clk);
        check("lat_vis_3", mario_vis, 1'b0);

        // Walk right: rr1 x6, rr2 x6, rr3 x6, rr1.
        mario   = 1'b1;
        keycode = 16'h0007;
        for (int f = 1; f <= 19; f++) begin
            frame();
            case (((f - 1) / 6) % 3)
                0:       exp_walk = C_RR1;
                1:       exp_walk = C_RR2;
                default: exp_walk = C_RR3;
            endcase
            check($sformatf("walk_pic_f%0d", f), mario_pic_out, exp_walk);
        end
        check("walk_state",  anim_state,  ST_WALK);
        check("walk_facing", facing_left, 1'b0);
        check("walk_vis",    mario_vis,   1'b1);

        // Left key in the high byte turns Mario around mid-walk.
        keycode = 16'h0400;
        frame();
        check("left_facing", facing_left,   1'b1);
        check("left_state",  anim_state,    ST_WALK);
        check("left_pic",    mario_pic_out, C_RL1);

        // Both keys: stand, facing held.
        keycode = 16'h0407;
        frame();
        check("both_state",  anim_state,    ST_STAND);
        check("both_facing", facing_left,   1'b1);
        check("both_pic",    mario_pic_out, C_SL);

        // Airborne while holding left.
        keycode      = 16'h0004;
        mario_in_air = 1'b1;
        frame();
        check("jump_state", anim_state,    ST_JUMP);
        check("jump_pic",   mario_pic_out, C_JL);

        // Death beats in-air.
        mario_alive = 1'b0;
        frame();
        check("dead_state", anim_state,    ST_DEAD);
        check("dead_pic",   mario_pic_out, C_DIE);

        // Death is sticky.
        keycode      = 16'h0;
        mario_in_air = 1'b0;
        mario_alive  = 1'b1;
        repeat (2) frame();
        check("sticky_state", anim_state,    ST_DEAD);
        check("sticky_pic",   mario_pic_out, C_DIE);

        // Fresh start, then transparency keying on the standing frame.
        @(negedge Clk) Reset = 1'b1;
        @(negedge Clk) Reset = 1'b0;
        mario_sr = 24'hFF00FF;
        repeat (3) @(negedge Clk);
        check("key_vis", mario_vis,     1'b0);
        check("key_pic", mario_pic_out, 24'hFF00FF);
        mario_sr = 24'hFF00FE;
        repeat (2) @(negedge Clk);
        check("nokey_vis", mario_vis,     1'b1);
        check("nokey_pic", mario_pic_out, 24'hFF00FE);
        mario_sr = C_SR;

        // Walk into phase 2, then reset with frame_clk high.
        keycode = 16'h0007;
        repeat (13) frame();
        check("pre_rst_pic", mario_pic_out, C_RR3);
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk) Reset = 1'b1;
        #1;
        check("mid_rst_pic",   mario_pic_out, 24'h0);
        check("mid_rst_vis",   mario_vis,     1'b0);
        check("mid_rst_state", anim_state,    ST_STAND);
        @(negedge Clk) Reset = 1'b0;
        repeat (3) @(negedge Clk);
        check("no_tick_state", anim_state,    ST_STAND);
        check("no_tick_pic",   mario_pic_out, C_SR);
        @(negedge Clk) frame_clk = 1'b0;
        @(negedge Clk);
        frame();
        check("rewalk_state", anim_state,    ST_WALK);
        check("rewalk_pic",   mario_pic_out, C_RR1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
